// File: rtl/reg_file_8x16.sv
// -----------------------------------------------------------------------------
// reg_file_8x16
//   Operand register file sitting directly in front of the 16-bit ALU.
//   Two combinational read ports feed ALU i0/i1. One synchronous write port
//   captures the ALU result and its carry-out, which closes the
//   register -> ALU -> register loop in a single clock period.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset; wins over wr_i
//   wr_i         write enable
//   wr_addr_i    destination register (writes to r0 are dropped)
//   d_in_i       write data (ALU o), stored unmodified
//   c_in_i       carry to capture (ALU cout); updates on any write, even to r0
//   rd_addr_a_i  read port A select
//   rd_addr_b_i  read port B select
//   d_out_a_o    r[rd_addr_a_i], combinational (ALU i0)
//   d_out_b_o    r[rd_addr_b_i], combinational (ALU i1)
//   carry_o      registered carry flag
// -----------------------------------------------------------------------------
module reg_file_8x16 #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  d_in_i,
  input  logic              c_in_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic [WIDTH-1:0]  d_out_a_o,
  output logic [WIDTH-1:0]  d_out_b_o,
  output logic              carry_o
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic                        carry_q, carry_d;

  // Next-state: a write to r0 is dropped, but the carry still follows c_in_i
  // so flag-only operations can target r0.
  always_comb begin
    regs_d  = regs_q;
    carry_d = carry_q;
    if (wr_i) begin
      if (wr_addr_i != '0) regs_d[wr_addr_i] = d_in_i;
      carry_d = c_in_i;
    end
  end

  // Reset takes priority, so a write pending in the reset cycle is lost.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      regs_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      carry_q <= carry_d;
    end
  end

  // Reads come straight off the flops, so there is no write-to-read bypass:
  // a same-cycle write only becomes visible after the edge. Address 0 is
  // forced to zero on the read side as well, independent of the r0 flops.
  assign d_out_a_o = (rd_addr_a_i == '0) ? '0 : regs_q[rd_addr_a_i];
  assign d_out_b_o = (rd_addr_b_i == '0) ? '0 : regs_q[rd_addr_b_i];
  assign carry_o   = carry_q;

endmodule
